// File: rtl/cpu_debug_scanner_pkg.sv
// Shared encodings for the CPU debug scanner: record kinds, FSM states, register count.
package cpu_debug_scanner_pkg;
  typedef enum logic [1:0] {
    KIND_PC   = 2'd0,
    KIND_INST = 2'd1,
    KIND_REG  = 2'd2,
    KIND_MEM  = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PC   = 3'd1,
    S_INST = 3'd2,
    S_REG  = 3'd3,
    S_MEM  = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  localparam int REG_COUNT = 32;

  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + 32'd4;
  endfunction
endpackage

// File: rtl/cpu_debug_scanner.sv
// Walks PC/INST snapshot, all 32 registers and a data-RAM window, emitting one
// record per value on a valid/ready stream with a single registered output slot.
module cpu_debug_scanner
  import cpu_debug_scanner_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          MEM_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [7:0]  out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);
  localparam bit         HAS_MEM  = (MEM_WORDS != 0);
  localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);
  localparam logic [7:0] LAST_REG = 8'(REG_COUNT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_snap_q, pc_snap_d;
  logic [31:0] inst_snap_q, inst_snap_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        valid_q, valid_d;
  kind_e       kind_q, kind_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hs;

  assign hs = valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    pc_snap_d   = pc_snap_q;
    inst_snap_d = inst_snap_q;
    rf_addr_d   = rf_addr_q;
    mem_addr_d  = mem_addr_q;
    valid_d     = valid_q;
    kind_d      = kind_q;
    index_d     = index_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        // The PC slot takes cpu_pc directly so it matches the snapshot taken now.
        state_d     = S_PC;
        pc_snap_d   = cpu_pc;
        inst_snap_d = cpu_inst;
        valid_d     = 1'b1;
        kind_d      = KIND_PC;
        index_d     = 8'd0;
        data_d      = cpu_pc;
        busy_d      = 1'b1;
        rf_addr_d   = 5'd0;
        mem_addr_d  = MEM_BASE;
      end
      S_PC: if (hs) begin
        state_d = S_INST;
        kind_d  = KIND_INST;
        data_d  = inst_snap_q;
      end
      S_INST: if (hs) begin
        state_d   = S_REG;
        kind_d    = KIND_REG;
        index_d   = 8'd0;
        data_d    = rf_data;
        rf_addr_d = rf_addr_q + 5'd1;
      end
      S_REG: if (hs) begin
        if (index_q != LAST_REG) begin
          index_d   = index_q + 8'd1;
          data_d    = rf_data;
          rf_addr_d = rf_addr_q + 5'd1;
        end else if (HAS_MEM) begin
          state_d    = S_MEM;
          kind_d     = KIND_MEM;
          index_d    = 8'd0;
          data_d     = mem_data;
          mem_addr_d = next_word(mem_addr_q);
        end else begin
          state_d = S_FIN;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_MEM: if (hs) begin
        if (index_q != LAST_MEM) begin
          index_d    = index_q + 8'd1;
          data_d     = mem_data;
          mem_addr_d = next_word(mem_addr_q);
        end else begin
          state_d = S_FIN;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_FIN: begin
        state_d    = S_IDLE;
        rf_addr_d  = 5'd0;
        mem_addr_d = MEM_BASE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_snap_q   <= 32'd0;
      inst_snap_q <= 32'd0;
      rf_addr_q   <= 5'd0;
      mem_addr_q  <= MEM_BASE;
      valid_q     <= 1'b0;
      kind_q      <= KIND_PC;
      index_q     <= 8'd0;
      data_q      <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_snap_q   <= pc_snap_d;
      inst_snap_q <= inst_snap_d;
      rf_addr_q   <= rf_addr_d;
      mem_addr_q  <= mem_addr_d;
      valid_q     <= valid_d;
      kind_q      <= kind_d;
      index_q     <= index_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf_addr   = rf_addr_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = valid_q;
  assign out_kind  = kind_q;
  assign out_index = index_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
